// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one uart_tx register port between NREQ byte requesters. Requesters
//   are served in round-robin order. For each byte the block polls the UART
//   status register until the busy bit clears. It then writes the byte to the
//   TX data register and pulses ack for the requester.
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous, active-high
//   req        req[i]=1: requester i presents a byte on req_data
//   req_data   byte of requester i at [8*i+7:8*i]
//   ack        one-cycle pulse: byte of requester i has been consumed
//   err        one-cycle pulse alongside ack when the byte was dropped on timeout
//   grant_id   index of the current / last granted requester
//   busy       1 whenever the arbiter is not idle
//   uart_wren, uart_rden, uart_addr, uart_din   uart_tx register bus (sole master)
//   uart_dout  uart_tx read data, valid the cycle after uart_rden
//
// Configuration
//   UART_ARB_TIMEOUT_EN  when defined, a poll that lasts TIMEOUT cycles drops
//                        the byte and reports err with ack. When undefined,
//                        polling never gives up and err is tied low.
//
// Handshake: a requester holds req[i]/req_data while waiting. Requests are
// sampled only in IDLE, and the byte is latched at grant. The requester may
// present its next byte on the edge that ends its ack cycle; IDLE picks it up
// on the following cycle, so back-to-back bytes need no gap.
module uart_tx_arbiter #(
    parameter int          NREQ      = 2,
    parameter logic [2:0]  DATA_ADDR = 3'd0,
    parameter logic [2:0]  STAT_ADDR = 3'd1,
    parameter int          BUSY_BIT  = 0,
    parameter logic [15:0] TIMEOUT   = 16'd4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   ack,
    output logic              err,
    output logic [1:0]        grant_id,
    output logic              busy,
    output logic              uart_wren,
    output logic              uart_rden,
    output logic [2:0]        uart_addr,
    output logic [7:0]        uart_din,
    input  logic [7:0]        uart_dout
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_STAT   = 3'd1,
        WAIT_STAT = 3'd2,
        WRITE     = 3'd3,
        ACK       = 3'd4
    } state_t;

    // state is left as a named register so that checkers can bind to it
    state_t          state, state_n;
    logic [1:0]      last, last_n;
    logic [1:0]      grant_n;
    logic [7:0]      tx_byte, tx_byte_n;
    logic            rden_n, wren_n, busy_n;
    logic [2:0]      addr_n;
    logic [7:0]      din_n;
    logic [NREQ-1:0] ack_n;
    logic            found;

`ifdef UART_ARB_TIMEOUT_EN
    logic [15:0]     poll_cnt, poll_cnt_n;
    logic            err_n;
`endif

    // Only uart_dout[BUSY_BIT] carries meaning for this block
    logic unused_dout;
    assign unused_dout = ^uart_dout;

    always_comb begin
        state_n   = state;
        last_n    = last;
        grant_n   = grant_id;
        tx_byte_n = tx_byte;
        found     = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        poll_cnt_n = poll_cnt;
        err_n      = 1'b0;
`endif

        case (state)
            IDLE: begin
                // Rotating search starting one past the last served requester
                for (int k = 1; k <= NREQ; k++) begin
                    for (int j = 0; j < NREQ; j++) begin
                        if (!found && (j == (int'(last) + k) % NREQ) && req[j]) begin
                            found     = 1'b1;
                            grant_n   = 2'(j);
                            tx_byte_n = req_data[8*j +: 8];
                        end
                    end
                end
                if (found) begin
                    state_n = RD_STAT;
`ifdef UART_ARB_TIMEOUT_EN
                    poll_cnt_n = '0;
`endif
                end
            end

            RD_STAT: begin
`ifdef UART_ARB_TIMEOUT_EN
                poll_cnt_n = poll_cnt + 16'd1;
                if (poll_cnt_n >= TIMEOUT) begin
                    state_n = ACK;
                    err_n   = 1'b1;
                end else begin
                    state_n = WAIT_STAT;
                end
`else
                state_n = WAIT_STAT;
`endif
            end

            WAIT_STAT: begin
`ifdef UART_ARB_TIMEOUT_EN
                poll_cnt_n = poll_cnt + 16'd1;
                // A free UART wins over a timeout hitting in the same cycle
                if (!uart_dout[BUSY_BIT]) begin
                    state_n = WRITE;
                end else if (poll_cnt_n >= TIMEOUT) begin
                    state_n = ACK;
                    err_n   = 1'b1;
                end else begin
                    state_n = RD_STAT;
                end
`else
                state_n = uart_dout[BUSY_BIT] ? RD_STAT : WRITE;
`endif
            end

            WRITE: begin
                state_n = ACK;
            end

            ACK: begin
                last_n  = grant_id;
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        // All outputs are registered. They are decoded from the next state,
        // so each strobe lines up exactly with its state.
        rden_n = (state_n == RD_STAT);
        wren_n = (state_n == WRITE);
        busy_n = (state_n != IDLE);
        addr_n = uart_addr;
        din_n  = uart_din;
        if (rden_n) begin
            addr_n = STAT_ADDR;
        end
        if (wren_n) begin
            addr_n = DATA_ADDR;
            din_n  = tx_byte_n;
        end
        for (int j = 0; j < NREQ; j++) begin
            ack_n[j] = (state_n == ACK) && (grant_n == 2'(j));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            last      <= 2'(NREQ - 1);
            grant_id  <= '0;
            tx_byte   <= '0;
            uart_rden <= 1'b0;
            uart_wren <= 1'b0;
            uart_addr <= '0;
            uart_din  <= '0;
            ack       <= '0;
            busy      <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            poll_cnt  <= '0;
            err       <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            last      <= last_n;
            grant_id  <= grant_n;
            tx_byte   <= tx_byte_n;
            uart_rden <= rden_n;
            uart_wren <= wren_n;
            uart_addr <= addr_n;
            uart_din  <= din_n;
            ack       <= ack_n;
            busy      <= busy_n;
`ifdef UART_ARB_TIMEOUT_EN
            poll_cnt  <= poll_cnt_n;
            err       <= err_n;
`endif
        end
    end

`ifndef UART_ARB_TIMEOUT_EN
    assign err = 1'b0;
    logic [15:0] unused_timeout;
    assign unused_timeout = TIMEOUT;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int         NREQ      = 2;
    localparam logic [2:0] DATA_ADDR = 3'd0;
    localparam logic [2:0] STAT_ADDR = 3'd1;
    localparam int         BUSY_BIT  = 0;
    localparam int         MAXB      = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   ack;
    logic              err;
    logic [1:0]        grant_id;
    logic              busy;
    logic              uart_wren;
    logic              uart_rden;
    logic [2:0]        uart_addr;
    logic [7:0]        uart_din;
    logic [7:0]        uart_dout;

    uart_tx_arbiter #(
        .NREQ(NREQ), .DATA_ADDR(DATA_ADDR), .STAT_ADDR(STAT_ADDR),
        .BUSY_BIT(BUSY_BIT), .TIMEOUT(16'd20)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data),
        .ack(ack), .err(err), .grant_id(grant_id), .busy(busy),
        .uart_wren(uart_wren), .uart_rden(uart_rden), .uart_addr(uart_addr),
        .uart_din(uart_din), .uart_dout(uart_dout)
    );

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // ---------------- requester and UART models ----------------
    logic [7:0] src_mem [NREQ][MAXB];
    int         src_len [NREQ];
    int         src_head[NREQ];

    logic [7:0] exp_q[$];
    int         exp_id_q[$];
    int         model_last = NREQ - 1;

    int   busy_left  = 0;
    int   polls_seen = 0;
    int   polls_exp  = 1;
    logic stuck_busy = 1'b0;
    logic to_mode    = 1'b0;

    logic       wr_prev    = 1'b0;
    int         wr_prev_id = 0;
    int         cyc        = 0;
    int         writes     = 0;
    int         t_wren     = 0;
    int         t_ack      = 0;
    int         t_start    = 0;
    logic       ack_seen   = 1'b0;
    logic [NREQ-1:0] ack_val = '0;
    logic       err_val    = 1'b0;

    task automatic clear_src();
        for (int i = 0; i < NREQ; i++) begin
            src_len[i]  = 0;
            src_head[i] = 0;
        end
    endtask

    task automatic push_src(input int i, input logic [7:0] b);
        src_mem[i][src_len[i]] = b;
        src_len[i]++;
    endtask

    task automatic drive_req();
        for (int i = 0; i < NREQ; i++) begin
            if (src_head[i] < src_len[i]) begin
                req[i]             = 1'b1;
                req_data[8*i +: 8] = src_mem[i][src_head[i]];
            end else begin
                req[i]             = 1'b0;
                req_data[8*i +: 8] = 8'h00;
            end
        end
    endtask

    // Round-robin over the pending byte lists: the written sequence follows
    // from the list contents alone, because every requester re-presents its
    // next byte right after its ack.
    task automatic build_expected();
        int  pend[NREQ];
        int  idx;
        logic hit;
        for (int i = 0; i < NREQ; i++) pend[i] = src_head[i];
        for (int n = 0; n < NREQ * MAXB; n++) begin
            hit = 1'b0;
            for (int k = 1; k <= NREQ; k++) begin
                idx = (model_last + k) % NREQ;
                if (!hit && pend[idx] < src_len[idx]) begin
                    hit = 1'b1;
                    exp_q.push_back(src_mem[idx][pend[idx]]);
                    exp_id_q.push_back(idx);
                    pend[idx]++;
                    model_last = idx;
                end
            end
        end
    endtask

    // One clock: sample at negedge, check, then drive the next inputs
    task automatic tick();
        logic [NREQ-1:0] exp_ack;
        @(negedge clk);
        cyc++;
        check("strobe_excl", 32'(uart_wren & uart_rden), 32'd0);
        for (int i = 0; i < NREQ; i++) exp_ack[i] = wr_prev && (i == wr_prev_id);
        if (!to_mode) begin
            check("ack", 32'(ack), 32'(exp_ack));
            check("err", 32'(err), 32'd0);
        end
        if (ack != '0 && !ack_seen) begin
            ack_seen = 1'b1;
            ack_val  = ack;
            err_val  = err;
        end
        wr_prev = 1'b0;

        if (uart_rden) begin
            check("rd_addr", 32'(uart_addr), 32'(STAT_ADDR));
            polls_seen++;
            uart_dout = 8'($urandom);
            uart_dout[BUSY_BIT] = stuck_busy || (busy_left > 0);
            if (busy_left > 0) busy_left--;
        end

        if (uart_wren) begin
            writes++;
            t_wren = cyc;
            check("wr_addr", 32'(uart_addr), 32'(DATA_ADDR));
            check("wr_busy", 32'(busy), 32'd1);
            check("polls", 32'(polls_seen), 32'(polls_exp));
            if (exp_q.size() == 0) begin
                check("extra_write", 32'd1, 32'd0);
            end else begin
                check("din", 32'(uart_din), 32'(exp_q.pop_front()));
                wr_prev_id = exp_id_q.pop_front();
                check("grant_id", 32'(grant_id), 32'(wr_prev_id));
                wr_prev = 1'b1;
            end
            busy_left  = $urandom_range(0, 3);
            polls_exp  = busy_left + 1;
            polls_seen = 0;
        end

        if (ack != '0) t_ack = cyc;
        for (int i = 0; i < NREQ; i++) begin
            if (ack[i]) src_head[i]++;
        end
        drive_req();
    endtask

    task automatic run_phase(input string tag, input int busy0, input int budget);
        int n;
        build_expected();
        busy_left  = busy0;
        polls_exp  = busy0 + 1;
        polls_seen = 0;
        drive_req();
        t_start = cyc;
        n = 0;
        while ((exp_q.size() != 0 || wr_prev) && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_done"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        exp_id_q.delete();
        tick();
        tick();
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int w0;
        int n;
        reset     = 1'b1;
        req       = '0;
        req_data  = '0;
        uart_dout = 8'h00;
        clear_src();

        // reset held, then idle with no requests
        repeat (3) tick();
        check("rst_out", 32'({ack, err, grant_id, busy, uart_wren, uart_rden, uart_addr, uart_din}), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_out", 32'({ack, err, grant_id, busy, uart_wren, uart_rden, uart_addr, uart_din}), 32'd0);
        end

        // two requesters held through four bytes: strict alternation from req[0]
        clear_src();
        push_src(0, 8'hA1); push_src(0, 8'hA1);
        push_src(1, 8'hB2); push_src(1, 8'hB2);
        w0 = writes;
        run_phase("alt", 0, 100);
        check("alt_writes", 32'(writes - w0), 32'd4);

        // single request, UART idle: write at +3, ack at +4
        clear_src();
        push_src(0, 8'h55);
        w0 = writes;
        run_phase("lat", 0, 50);
        check("lat_writes", 32'(writes - w0), 32'd1);
        check("lat_wren", 32'(t_wren - t_start), 32'd3);
        check("lat_ack", 32'(t_ack - t_start), 32'd4);

        // UART busy for 5 polls: 6 status reads then one write
        clear_src();
        push_src(0, 8'h5A);
        w0 = writes;
        run_phase("poll", 5, 100);
        check("poll_writes", 32'(writes - w0), 32'd1);

        // reset while waiting on status: byte abandoned, rotation restarts
        clear_src();
        push_src(0, 8'h11);
        push_src(1, 8'h22);
        busy_left  = 0;
        polls_exp  = 1;
        polls_seen = 0;
        drive_req();
        w0 = writes;
        n = 0;
        while (!uart_rden && n < 20) begin
            tick();
            n++;
        end
        check("rst_rd_seen", 32'(uart_rden), 32'd1);
        tick();
        reset = 1'b1;
        repeat (3) tick();
        check("rst_nowrite", 32'(writes - w0), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        model_last = NREQ - 1;
        run_phase("rst", 0, 100);
        check("rst_writes", 32'(writes - w0), 32'd2);

`ifdef UART_ARB_TIMEOUT_EN
        // status stuck busy: ack+err together, no write, byte discarded
        clear_src();
        push_src(0, 8'h77);
        to_mode    = 1'b1;
        stuck_busy = 1'b1;
        ack_seen   = 1'b0;
        w0 = writes;
        drive_req();
        t_start = cyc;
        n = 0;
        while (!ack_seen && n < 60) begin
            tick();
            n++;
        end
        check("to_seen", 32'(ack_seen), 32'd1);
        check("to_ack", 32'(ack_val), 32'd1);
        check("to_err", 32'(err_val), 32'd1);
        check("to_lat", 32'((t_ack - t_start) <= 22), 32'd1);
        check("to_nowrite", 32'(writes - w0), 32'd0);
        tick();
        tick();
        to_mode    = 1'b0;
        stuck_busy = 1'b0;
        model_last = 0;
        clear_src();
        push_src(0, 8'h99);
        push_src(1, 8'h88);
        run_phase("to_next", 0, 100);
`endif

        // randomized rounds
        for (int r = 0; r < 8; r++) begin
            clear_src();
            for (int i = 0; i < NREQ; i++) begin
                int len;
                len = $urandom_range(0, 4);
                for (int b = 0; b < len; b++) push_src(i, 8'($urandom));
            end
            run_phase("rand", $urandom_range(0, 3), 400);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
